// File: rtl/helix_precision_ctrl.sv
// helix_precision_ctrl: closed-loop Reactor precision scheduler.
// Averages |feedback| per window, drains in-flight contexts, then switches mode.
`ifndef HELIX_FEEDBACK_W
`define HELIX_FEEDBACK_W 16
`endif

module helix_precision_ctrl #(
  parameter int FEEDBACK_W   = `HELIX_FEEDBACK_W,
  parameter int WINDOW       = 8,
  parameter int HI_THRESH    = 100,
  parameter int LO_THRESH    = 10,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctx_accept,
  input  logic                  action_accept,
  input  logic                  feedback_valid,
  input  logic [FEEDBACK_W-1:0] feedback_delta,
  output logic                  ctx_hold,
  output logic [1:0]            precision_mode,
  output logic                  mode_changed,
  output logic                  protocol_err
);

  localparam int LW = $clog2(WINDOW);
  localparam int AW = FEEDBACK_W + LW;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH
  } state_t;

  state_t                state;
  logic [1:0]            target;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         acc;
  logic [LW-1:0]         scnt;
  logic [FEEDBACK_W-1:0] mag;
  logic [AW-1:0]         sum;
  logic [AW-1:0]         avg;
  logic                  last;
  logic                  go_up;
  logic                  go_dn;

  // magnitude of the sample; the most negative value maps to 2^(W-1)
  always_comb begin
    mag = feedback_delta;
    if (feedback_delta[FEEDBACK_W-1])
      mag = (~feedback_delta) + FEEDBACK_W'(1);
  end

  // window sum including this sample, average and step decision
  always_comb begin
    sum   = acc + AW'(mag);
    avg   = sum >> LW;
    last  = (scnt == LW'(WINDOW - 1));
    go_up = (64'(avg) > 64'(HI_THRESH)) && (precision_mode != 2'd3);
    go_dn = (64'(avg) < 64'(LO_THRESH)) && (precision_mode != 2'd0);
  end

  // hold decoded purely from registered state and count
  always_comb begin
    ctx_hold = (state != RUN) || (cnt == CMAX);
  end

  // in-flight context counter and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (action_accept && cnt == '0)
        protocol_err <= 1'b1;
      if (ctx_accept && ctx_hold)
        protocol_err <= 1'b1;
      if (ctx_accept && !action_accept) begin
        if (cnt != CMAX)
          cnt <= cnt + CW'(1);
      end else if (action_accept && !ctx_accept) begin
        if (cnt != '0)
          cnt <= cnt - CW'(1);
      end
    end
  end

  // window accumulation, decision, drain and mode switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      target         <= 2'd0;
      precision_mode <= 2'd0;
      mode_changed   <= 1'b0;
      acc            <= '0;
      scnt           <= '0;
    end else begin
      mode_changed <= 1'b0;
      unique case (state)
        RUN: begin
          if (feedback_valid) begin
            if (last) begin
              acc  <= '0;
              scnt <= '0;
              if (go_up) begin
                target <= precision_mode + 2'd1;
                state  <= DRAIN;
              end else if (go_dn) begin
                target <= precision_mode - 2'd1;
                state  <= DRAIN;
              end
            end else begin
              acc  <= sum;
              scnt <= scnt + LW'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == '0)
            state <= SWITCH;
        end
        SWITCH: begin
          precision_mode <= target;
          mode_changed   <= 1'b1;
          state          <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_helix_precision_ctrl.sv
// tb_helix_precision_ctrl: directed bench for helix_precision_ctrl.
// WINDOW=4, HI=100, LO=10, FEEDBACK_W=16, MAX_INFLIGHT=4.
`timescale 1ns/1ps

module tb_helix_precision_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ctx_accept;
  logic        action_accept;
  logic        feedback_valid;
  logic [15:0] feedback_delta;
  logic        ctx_hold;
  logic [1:0]  precision_mode;
  logic        mode_changed;
  logic        protocol_err;

  int checks;
  int failures;

  helix_precision_ctrl #(
    .FEEDBACK_W  (16),
    .WINDOW      (4),
    .HI_THRESH   (100),
    .LO_THRESH   (10),
    .MAX_INFLIGHT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctx_accept    (ctx_accept),
    .action_accept (action_accept),
    .feedback_valid(feedback_valid),
    .feedback_delta(feedback_delta),
    .ctx_hold      (ctx_hold),
    .precision_mode(precision_mode),
    .mode_changed  (mode_changed),
    .protocol_err  (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of strobes, then land 1ns after the edge
  task automatic cyc(input logic c, input logic a, input logic v,
                     input logic [15:0] d);
    ctx_accept     = c;
    action_accept  = a;
    feedback_valid = v;
    feedback_delta = d;
    @(posedge clk);
    #1;
    ctx_accept     = 1'b0;
    action_accept  = 1'b0;
    feedback_valid = 1'b0;
    feedback_delta = 16'd0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic win(input logic [15:0] d0, input logic [15:0] d1,
                     input logic [15:0] d2, input logic [15:0] d3);
    cyc(1'b0, 1'b0, 1'b1, d0);
    cyc(1'b0, 1'b0, 1'b1, d1);
    cyc(1'b0, 1'b0, 1'b1, d2);
    cyc(1'b0, 1'b0, 1'b1, d3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b1;
    ctx_accept     = 1'b0;
    action_accept  = 1'b0;
    feedback_valid = 1'b0;
    feedback_delta = 16'd0;

    // 1: asynchronous reset with no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mode", precision_mode, 0);
    chk("rst_hold", ctx_hold, 0);
    chk("rst_mc", mode_changed, 0);
    chk("rst_err", protocol_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2: step up, avg 175, no contexts outstanding
    win(16'd200, -16'sd200, 16'd150, -16'sd150);
    chk("up_drain_hold", ctx_hold, 1);
    chk("up_drain_mode", precision_mode, 0);
    idle();
    chk("up_sw_hold", ctx_hold, 1);
    chk("up_sw_mc", mode_changed, 0);
    idle();
    chk("up_mode", precision_mode, 1);
    chk("up_mc", mode_changed, 1);
    chk("up_hold", ctx_hold, 0);
    idle();
    chk("up_mc_end", mode_changed, 0);

    // 3: drain waits for two outstanding contexts
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("dw_hold0", ctx_hold, 0);
    win(16'd500, 16'd500, 16'd500, 16'd500);
    chk("dw_hold1", ctx_hold, 1);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    chk("dw_hold2", ctx_hold, 1);
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("dw_hold3", ctx_hold, 1);
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("dw_hold4", ctx_hold, 1);
    chk("dw_mode4", precision_mode, 1);
    idle();
    chk("dw_sw_hold", ctx_hold, 1);
    chk("dw_sw_mode", precision_mode, 1);
    idle();
    chk("dw_mode", precision_mode, 2);
    chk("dw_mc", mode_changed, 1);
    chk("dw_err", protocol_err, 0);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    chk("dw_fresh_win", ctx_hold, 0);
    cyc(1'b0, 1'b0, 1'b1, 16'd500);
    chk("dw_win_full", ctx_hold, 1);
    idle();
    idle();
    chk("m3_mode", precision_mode, 3);
    chk("m3_mc", mode_changed, 1);

    // 4: saturation at 3, thresholds, step down to 0
    win(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    chk("sat_hi_hold", ctx_hold, 0);
    chk("sat_hi_mc", mode_changed, 0);
    idle();
    idle();
    chk("sat_hi_mode", precision_mode, 3);
    chk("sat_hi_mc2", mode_changed, 0);
    win(16'd2, 16'd2, 16'd2, 16'd2);
    chk("dn2_hold", ctx_hold, 1);
    idle();
    idle();
    chk("dn2_mode", precision_mode, 2);
    chk("dn2_mc", mode_changed, 1);
    win(16'd100, 16'd100, 16'd100, 16'd103);
    chk("eq_hi_hold", ctx_hold, 0);
    idle();
    idle();
    chk("eq_hi_mode", precision_mode, 2);
    win(16'd10, 16'd10, 16'd10, 16'd10);
    chk("eq_lo_hold", ctx_hold, 0);
    idle();
    idle();
    chk("eq_lo_mode", precision_mode, 2);
    win(-16'sd9, 16'd9, -16'sd9, 16'd9);
    idle();
    idle();
    chk("dn1_mode", precision_mode, 1);
    win(16'd0, 16'd0, 16'd0, 16'd0);
    idle();
    idle();
    chk("dn0_mode", precision_mode, 0);
    win(16'd0, 16'd0, 16'd0, 16'd0);
    chk("sat_lo_hold", ctx_hold, 0);
    idle();
    idle();
    chk("sat_lo_mode", precision_mode, 0);
    chk("sat_lo_mc", mode_changed, 0);

    // 5: counter boundaries and protocol errors
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("err_act0", protocol_err, 1);
    do_reset();
    chk("err_clr", protocol_err, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("cnt3_hold", ctx_hold, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("cnt4_hold", ctx_hold, 1);
    chk("cnt4_err", protocol_err, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("ctx5_err", protocol_err, 1);
    chk("ctx5_hold", ctx_hold, 1);
    cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("both_hold", ctx_hold, 1);
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("cnt3b_hold", ctx_hold, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("cnt4b_hold", ctx_hold, 1);

    // 6: reset in the middle of a drain
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    win(16'd500, 16'd500, 16'd500, 16'd500);
    idle();
    chk("md_hold", ctx_hold, 1);
    rst_n = 1'b0;
    #1;
    chk("md_rst_hold", ctx_hold, 0);
    chk("md_rst_mode", precision_mode, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("md_post_mc", mode_changed, 0);
      chk("md_post_hold", ctx_hold, 0);
    end
    chk("md_post_mode", precision_mode, 0);
    chk("md_post_err", protocol_err, 0);
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("md_cnt0_err", protocol_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time bound in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout observed=stall expected=finish");
    $fatal(1, "timeout");
  end

endmodule
